// File: rtl/motion_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// motion_cmd_sequencer
//
// Purpose:
//   Steps a pick-and-place arm through a fixed 13-step recipe once per part,
//   repeats the recipe for BATCH parts, then homes the arm. Steps 7 and 10
//   (picks) are gated on the cooling/trimming station being ready. A watchdog
//   faults the block if an awaited acknowledgement never arrives.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   level, starts a batch when sampled in IDLE
//   stop           in   level, aborts any activity (ignored in FAULT)
//   clear_fault    in   level, leaves FAULT
//   actuator_done  in   one-cycle pulse, arm finished the current command
//   station_ready  in   level, station finished its work
//   motion_cmd     out  [2:0] 000 move, 001 pick, 010 place, 011 home,
//                       100 stop, 111 nop
//   cmd_valid      out  one-cycle strobe, one per issued command
//   busy           out  high outside IDLE and FAULT
//   fault          out  high in FAULT
//   step           out  [3:0] current recipe index
//   parts_done     out  [7:0] parts completed in the current batch
//   fsm_state      out  [2:0] FSM state, debug visibility
//
// Handshake:
//   motion_cmd/cmd_valid are a one-way strobe: the command is valid for the
//   single cycle cmd_valid is high and stays on motion_cmd while the block
//   waits; there is no ready, the arm answers later with actuator_done.
//
// Timing:
//   motion_cmd, cmd_valid, busy and fault come from an output register fed by
//   the current FSM state, so they follow the state by one clock. step and
//   parts_done are the working registers themselves.
// -----------------------------------------------------------------------------
module motion_cmd_sequencer #(
    parameter int BATCH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_fault,
    input  logic       actuator_done,
    input  logic       station_ready,
    output logic [2:0] motion_cmd,
    output logic       cmd_valid,
    output logic       busy,
    output logic       fault,
    output logic [3:0] step,
    output logic [7:0] parts_done,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ISSUE      = 3'd1;
    localparam logic [2:0] S_WAIT_ACK   = 3'd2;
    localparam logic [2:0] S_WAIT_STN   = 3'd3;
    localparam logic [2:0] S_HOME_ISSUE = 3'd4;
    localparam logic [2:0] S_HOME_WAIT  = 3'd5;
    localparam logic [2:0] S_FAULT      = 3'd6;

    localparam logic [2:0] CMD_MOVE  = 3'b000;
    localparam logic [2:0] CMD_PICK  = 3'b001;
    localparam logic [2:0] CMD_PLACE = 3'b010;
    localparam logic [2:0] CMD_HOME  = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b100;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    localparam logic [3:0]  LAST_STEP = 4'd12;
    localparam logic [15:0] WD_LIMIT  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  BATCH_N   = 8'(BATCH);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [3:0]  step_next;
    logic [7:0]  parts_next;
    logic [7:0]  parts_inc;
    logic [15:0] wd;
    logic [15:0] wd_next;
    logic        wd_expired;
    logic        in_wait_next;
    logic        stop_mark;
    logic        stop_mark_next;

    logic [2:0]  cmd_comb;
    logic        valid_comb;
    logic        busy_comb;
    logic        fault_comb;

    // Recipe table: the command issued at each step of one part.
    function automatic logic [2:0] recipe_cmd(input logic [3:0] idx);
        logic [2:0] c;
        case (idx)
            4'd0, 4'd2, 4'd5, 4'd8, 4'd11: c = CMD_MOVE;
            4'd1, 4'd4, 4'd7, 4'd10:       c = CMD_PICK;
            4'd3, 4'd6, 4'd9, 4'd12:       c = CMD_PLACE;
            default:                       c = CMD_NOP;
        endcase
        return c;
    endfunction

    assign parts_inc  = parts_done + 8'd1;
    assign wd_expired = (wd == WD_LIMIT);
    assign fsm_state  = state;

    // ------------------------------------------------------------------
    // State and working registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            step       <= 4'd0;
            parts_done <= 8'd0;
            wd         <= 16'd0;
            stop_mark  <= 1'b0;
        end else begin
            state      <= state_next;
            step       <= step_next;
            parts_done <= parts_next;
            wd         <= wd_next;
            stop_mark  <= stop_mark_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. stop is checked first so that it beats every other
    // event in the same cycle; FAULT is the only state it cannot leave.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        step_next      = step;
        parts_next     = parts_done;
        stop_mark_next = 1'b0;

        if (stop && (state != S_FAULT)) begin
            state_next     = S_IDLE;
            step_next      = 4'd0;
            stop_mark_next = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_ISSUE;
                        step_next  = 4'd0;
                        parts_next = 8'd0;
                    end
                end
                S_ISSUE: begin
                    state_next = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // An acknowledgement in the watchdog's last cycle wins.
                    if (actuator_done) begin
                        if (step == LAST_STEP) begin
                            parts_next = parts_inc;
                            if (parts_inc == BATCH_N) begin
                                state_next = S_HOME_ISSUE;
                            end else begin
                                step_next  = 4'd0;
                                state_next = S_ISSUE;
                            end
                        end else if ((step == 4'd6) || (step == 4'd9)) begin
                            step_next  = step + 4'd1;
                            state_next = S_WAIT_STN;
                        end else begin
                            step_next  = step + 4'd1;
                            state_next = S_ISSUE;
                        end
                    end else if (wd_expired) begin
                        state_next = S_FAULT;
                    end
                end
                S_WAIT_STN: begin
                    if (station_ready) begin
                        state_next = S_ISSUE;
                    end else if (wd_expired) begin
                        state_next = S_FAULT;
                    end
                end
                S_HOME_ISSUE: begin
                    state_next = S_HOME_WAIT;
                end
                S_HOME_WAIT: begin
                    if (actuator_done) begin
                        state_next = S_IDLE;
                        step_next  = 4'd0;
                    end else if (wd_expired) begin
                        state_next = S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state_next = S_IDLE;
                        step_next  = 4'd0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    step_next  = 4'd0;
                end
            endcase
        end
    end

    // Watchdog: restarts from zero on every entry into a waiting state
    // (including the direct WAIT_ACK -> WAIT_STN hop) and counts while there.
    always_comb begin
        in_wait_next = (state_next == S_WAIT_ACK) ||
                       (state_next == S_WAIT_STN) ||
                       (state_next == S_HOME_WAIT);
        if (in_wait_next && (state_next != state)) begin
            wd_next = 16'd0;
        end else if (in_wait_next) begin
            wd_next = wd + 16'd1;
        end else begin
            wd_next = 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the current state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_comb   = CMD_NOP;
        valid_comb = 1'b0;
        busy_comb  = 1'b1;
        fault_comb = 1'b0;
        case (state)
            S_IDLE: begin
                // One stop command follows an abort, then back to nop.
                cmd_comb  = stop_mark ? CMD_STOP : CMD_NOP;
                busy_comb = 1'b0;
            end
            S_ISSUE: begin
                cmd_comb   = recipe_cmd(step);
                valid_comb = 1'b1;
            end
            S_WAIT_ACK: begin
                cmd_comb = recipe_cmd(step);
            end
            S_WAIT_STN: begin
                cmd_comb = CMD_NOP;
            end
            S_HOME_ISSUE: begin
                cmd_comb   = CMD_HOME;
                valid_comb = 1'b1;
            end
            S_HOME_WAIT: begin
                cmd_comb = CMD_HOME;
            end
            S_FAULT: begin
                cmd_comb   = CMD_STOP;
                busy_comb  = 1'b0;
                fault_comb = 1'b1;
            end
            default: begin
                cmd_comb  = CMD_NOP;
                busy_comb = 1'b0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            motion_cmd <= CMD_NOP;
            cmd_valid  <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            motion_cmd <= cmd_comb;
            cmd_valid  <= valid_comb;
            busy       <= busy_comb;
            fault      <= fault_comb;
        end
    end

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_motion_cmd_sequencer;

    localparam int BATCH   = 2;
    localparam int TIMEOUT = 64;
    localparam int LIMIT   = 5000;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear_fault = 1'b0;
    logic       actuator_done = 1'b0;
    logic       station_ready;
    logic [2:0] motion_cmd;
    logic       cmd_valid;
    logic       busy;
    logic       fault;
    logic [3:0] step;
    logic [7:0] parts_done;
    logic [2:0] fsm_state;

    always #5 clock = ~clock;

    motion_cmd_sequencer #(.BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .clear_fault   (clear_fault),
        .actuator_done (actuator_done),
        .station_ready (station_ready),
        .motion_cmd    (motion_cmd),
        .cmd_valid     (cmd_valid),
        .busy          (busy),
        .fault         (fault),
        .step          (step),
        .parts_done    (parts_done),
        .fsm_state     (fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int         total = 0;
    int         bad = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_cmd;
    logic [2:0] recipe[13] = '{3'b000, 3'b001, 3'b000, 3'b010,
                               3'b001, 3'b000, 3'b010,
                               3'b001, 3'b000, 3'b010,
                               3'b001, 3'b000, 3'b010};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected command stream for one full batch: every part runs the whole
    // recipe, then the arm is homed once.
    task automatic push_batch();
        for (int p = 0; p < BATCH; p++)
            for (int s = 0; s < 13; s++)
                exp_q.push_back(recipe[s]);
        exp_q.push_back(3'b011);
    endtask

    // ------------------------------------------------------------------
    // Environment: arm responder and station model
    // ------------------------------------------------------------------
    bit ack_en = 1'b0;
    bit ack_rand = 1'b0;
    int ack_fixed = 3;
    int ack_cnt = 0;

    always @(negedge clock) begin
        actuator_done = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) actuator_done = 1'b1;
        end
        if (!reset && cmd_valid && ack_en)
            ack_cnt = ack_rand ? int'($urandom_range(1, 5)) : ack_fixed;
    end

    logic stn_mode = 1'b0;
    logic stn_level = 1'b1;
    logic stn_rand = 1'b1;
    always @(negedge clock) stn_rand = ($urandom_range(0, 3) != 0);
    assign station_ready = stn_mode ? stn_rand : stn_level;

    // ------------------------------------------------------------------
    // Monitor: every command strobe is matched against the expected queue
    // ------------------------------------------------------------------
    always @(negedge clock) begin
        if (!reset && cmd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd: actual=%b required=none", motion_cmd);
            end else begin
                exp_cmd = exp_q.pop_front();
                check("cmd_seq", motion_cmd, exp_cmd);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_batch_done(input string name, output int fault_cycles);
        int n;
        n = 0;
        fault_cycles = 0;
        while ((exp_q.size() != 0 || busy) && n < LIMIT) begin
            @(negedge clock);
            if (fault) fault_cycles++;
            n++;
        end
        check(name, n < LIMIT, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd"},   motion_cmd, 3'b111);
        check({name, "_valid"}, cmd_valid, 0);
        check({name, "_busy"},  busy, 0);
        check({name, "_fault"}, fault, 0);
        check({name, "_step"},  step, 0);
        check({name, "_parts"}, parts_done, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int n;
    int k;
    int cnt;
    int fc;

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_cmd", motion_cmd, 3'b111);

        // Nominal batch, ack 3 cycles after each strobe, station always ready
        ack_en = 1'b1; ack_rand = 1'b0; ack_fixed = 3; stn_level = 1'b1;
        push_batch();
        pulse_start();
        wait_batch_done("batch_a_done", fc);
        check("batch_a_parts", parts_done, BATCH);
        check("batch_a_step", step, 0);
        check("batch_a_nofault", fc, 0);
        check("batch_a_idle_cmd", motion_cmd, 3'b111);

        // Station gate at step 7, raised 50 cycles later
        ack_fixed = 2; stn_level = 1'b0;
        push_batch();
        pulse_start();
        n = 0;
        while (step != 4'd7 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("stn_reach_step7", n < LIMIT, 1);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (motion_cmd !== 3'b111 || cmd_valid) cnt++;
        end
        check("stn_wait_nop", cnt, 0);
        stn_level = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!cmd_valid && n < 20);
        check("stn_issue_latency", n, 2);
        check("stn_issue_pick", motion_cmd, 3'b001);
        wait_batch_done("batch_b_done", fc);
        check("batch_b_parts", parts_done, BATCH);

        // Watchdog timeout with no acknowledgement
        ack_en = 1'b0;
        exp_q.push_back(3'b000);
        pulse_start();
        n = 0;
        while (!cmd_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("wd_first_cmd", n < 50, 1);
        // WAIT_ACK was entered on the edge just before this sample point.
        k = 0;
        while (!fault && k < TIMEOUT + 20) begin
            @(negedge clock);
            k++;
        end
        check("wd_fault_edge", k, TIMEOUT + 1);
        check("wd_fault_cmd", motion_cmd, 3'b100);
        check("wd_fault_busy", busy, 0);
        check("wd_fault_parts", parts_done, 0);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        repeat (2) @(negedge clock);
        check("fault_ignores_stop", fault, 1);
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
        @(negedge clock);
        check("clear_fault", fault, 0);
        check("clear_fault_cmd", motion_cmd, 3'b111);
        check("clear_fault_step", step, 0);

        // Acknowledgement lands in the watchdog's last cycle every time
        ack_en = 1'b1; ack_fixed = TIMEOUT - 1;
        push_batch();
        pulse_start();
        wait_batch_done("wd_edge_done", fc);
        check("wd_edge_nofault", fc, 0);
        check("wd_edge_parts", parts_done, BATCH);

        // stop together with actuator_done at step 5 of the second part
        ack_fixed = 3;
        push_batch();
        pulse_start();
        n = 0;
        while (!(cmd_valid && step == 4'd5 && parts_done == 8'd1) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("stop_reach_step5", n < LIMIT, 1);
        repeat (3) @(negedge clock);
        stop = 1'b1;
        exp_q.delete();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 0) stop = 1'b0;
            if (motion_cmd === 3'b100) cnt++;
        end
        check("stop_pulses", cnt, 1);
        check("stop_step", step, 0);
        check("stop_parts", parts_done, 1);
        check("stop_busy", busy, 0);
        check("stop_cmd_after", motion_cmd, 3'b111);

        // Asynchronous reset between edges in WAIT_ACK
        ack_fixed = 4;
        push_batch();
        pulse_start();
        n = 0;
        while (!(cmd_valid && step == 4'd2) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("rst_reach_step2", n < LIMIT, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        repeat (8) @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (motion_cmd !== 3'b111) cnt++;
        end
        check("rst_no_stop_pulse", cnt, 0);

        // Randomized batches: random ack delays and station readiness
        ack_rand = 1'b1; stn_mode = 1'b1;
        for (int b = 0; b < 2; b++) begin
            push_batch();
            pulse_start();
            wait_batch_done("rand_done", fc);
            check("rand_parts", parts_done, BATCH);
            check("rand_nofault", fc, 0);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL global_timeout: actual=expired required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motion_cmd_sequencer.md
MOTION_CMD_SEQUENCER -- requirements
Module: motion_cmd_sequencer

Interface
REQ-001 Parameter BATCH, default 4, number of parts per run (1..255).
REQ-002 Parameter TIMEOUT, default 1000, watchdog limit in cycles (2..65535).
REQ-003 clock  input  1  single clock; every register changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; forces the reset values immediately.
REQ-005 start  input  1  level; starts a batch when sampled high in IDLE.
REQ-006 stop  input  1  level; aborts any activity.
REQ-007 clear_fault  input  1  level; leaves FAULT.
REQ-008 actuator_done  input  1  one-cycle pulse; arm finished the current command.
REQ-009 station_ready  input  1  level; the cooling or trimming station has finished.
REQ-010 motion_cmd  output  3  command to the motion FSM: 000 move, 001 pick, 010 place, 011 home, 100 stop, 111 nop.
REQ-011 cmd_valid  output  1  high for exactly the one ISSUE cycle of each command.
REQ-012 busy  output  1  high in any state except IDLE and FAULT.
REQ-013 fault  output  1  high in FAULT.
REQ-014 step  output  4  current recipe index.
REQ-015 parts_done  output  8  parts completed in the current batch.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_STN, HOME_ISSUE, HOME_WAIT and FAULT.
REQ-018 The recipe SHALL be as follows, by step:
- 0 move; 1 pick; 2 move; 3 place
- 4 pick; 5 move; 6 place
- 7 pick (station-gated); 8 move; 9 place
- 10 pick (station-gated); 11 move; 12 place
REQ-019 IDLE with start=1 and stop=0 SHALL clear step and parts_done and enter ISSUE on the next edge.
REQ-020 ISSUE SHALL:
- drive the recipe command with cmd_valid=1 for one cycle;
- then enter WAIT_ACK.
REQ-021 WAIT_ACK SHALL hold motion_cmd at the same command with cmd_valid=0.
REQ-022 On actuator_done in WAIT_ACK, the following edges SHALL apply:
- step is 12: parts_done increments; if the new value equals BATCH, go to HOME_ISSUE; otherwise set step=0 and go to ISSUE.
- step is 6 or 9: increment step and go to WAIT_STN.
- any other step: increment step and go to ISSUE.
REQ-023 WAIT_STN SHALL drive motion_cmd=111 and enter ISSUE on the edge after station_ready is sampled high.
REQ-024 HOME_ISSUE SHALL:
- drive 011 with cmd_valid=1 for one cycle;
- then enter HOME_WAIT, which holds 011.
REQ-025 actuator_done in HOME_WAIT SHALL return the block to IDLE with step=0, keeping parts_done.
REQ-026 IDLE and FAULT SHALL drive motion_cmd=111, except that FAULT drives 100.
REQ-027 The watchdog counter (16 bits) SHALL clear on entry to WAIT_ACK, WAIT_STN or HOME_WAIT, and increment every cycle in those states.
REQ-028 If the counter reaches TIMEOUT-1 and the awaited signal is absent in that same cycle, the next edge SHALL enter FAULT, holding step and parts_done.
REQ-029 When the awaited signal arrives in the same cycle as the TIMEOUT-1 count, it SHALL win and no fault SHALL occur.
REQ-030 stop=1 in any state other than FAULT SHALL, on the next edge:
- enter IDLE;
- drive motion_cmd=100 for that one cycle, then 111;
- set step=0 and keep parts_done.
REQ-031 stop SHALL take priority over start, actuator_done, station_ready and timeout in the same cycle.
REQ-032 FAULT SHALL be left only by clear_fault=1 (to IDLE, step=0) or by reset; stop has no effect in FAULT.
REQ-033 start while busy, actuator_done outside WAIT_ACK/HOME_WAIT, and station_ready outside WAIT_STN SHALL be ignored.

Reset
REQ-034 While reset=1, the block SHALL hold:
- state=IDLE;
- motion_cmd=111, cmd_valid=0, busy=0, fault=0;
- step=0, parts_done=0, watchdog=0.
REQ-035 Reset asserted mid-command SHALL abandon the command with no stop pulse.
REQ-036 After reset deasserts, the block SHALL wait for a new start.

Verification
REQ-037 BATCH=1, with start pulsed and actuator_done returned 3 cycles after each cmd_valid (station_ready tied to 1):
- cmd_valid pulses carry the sequence 000,001,000,010,001,000,010,001,000,010,001,000,010,011;
- parts_done=1 at the end, then IDLE.
REQ-038 station_ready=0 at step 7, raised 50 cycles later: motion_cmd=111 throughout the wait, and 001 issues exactly 2 cycles after the raise.
REQ-039 TIMEOUT=8 with no actuator_done after step 0: fault=1 and motion_cmd=100 on the 9th edge after entering WAIT_ACK; clear_fault then returns IDLE with fault=0.
REQ-040 actuator_done in the watchdog's TIMEOUT-1 cycle: no fault, and step advances.
REQ-041 stop and actuator_done in the same cycle at step 5: IDLE, a single 100 pulse, step=0, parts_done unchanged.
REQ-042 Reset asserted asynchronously between clock edges during WAIT_ACK: all outputs reach reset values before the next edge; start is then accepted normally.
